// File: rtl/izh_pkg.sv
// Shared definitions for the Izhikevich neuron datapath: sample format,
// default spike/re-arm thresholds and the spike comparator state encoding.
package izh_pkg;

    localparam int V_W    = 8;
    localparam int V_FRAC = 6;

    localparam logic [V_W-1:0] TH_HI_DEF = 8'h13;  // +0.30 in signed 2.6
    localparam logic [V_W-1:0] TH_LO_DEF = 8'hF0;  // -0.25 in signed 2.6

    typedef enum logic {
        ARMED   = 1'b0,
        REFRACT = 1'b1
    } izh_state_e;

endpackage

// File: rtl/izh_isi_fifo.sv
// Register FIFO holding {first, isi} entries; head is presented on a
// valid/ready read port, pushes beyond capacity are refused unless a pop frees a slot.
module izh_isi_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [W-1:0]     push_data_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [LVL_W-1:0] level_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign valid_o = (level_q != '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // A pop in the same cycle makes room, so a full FIFO can still take a push.
    assign do_pop  = pop_i & valid_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/izh_spike_isi_encoder.sv
// Hysteresis spike detector with inter-spike-interval measurement and ISI FIFO.
// Optional spike-rate window enabled by defining IZH_SPIKE_RATE_EN.
module izh_spike_isi_encoder
    import izh_pkg::*;
#(
    parameter int ISI_W   = 16,
    parameter int DEPTH   = 4,
    parameter int WIN_LG2 = 8,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             v_valid,
    input  logic [V_W-1:0]   v_in,
    input  logic [V_W-1:0]   th_hi,
    input  logic [V_W-1:0]   th_lo,
    output logic             spike,
    output logic             isi_valid,
    input  logic             isi_ready,
    output logic [ISI_W-1:0] isi_data,
    output logic             isi_first,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic [7:0]       rate,
    output logic             rate_valid
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WIN_LG2 < 1 || ISI_W < 2) begin : g_bad_param
        $error("izh_spike_isi_encoder: illegal parameter combination");
    end

    izh_state_e       state_q, state_d;
    logic [ISI_W-1:0] cnt_q, cnt_d;
    logic [ISI_W-1:0] cnt_inc;
    logic             first_q, first_d;
    logic             spike_q;
    logic             overflow_q;
    logic             spike_det;
    logic             gt_hi;
    logic             lt_lo;
    logic             fifo_full;
    logic             pop;
    logic [ISI_W:0]   head;

    assign gt_hi   = $signed(v_in) > $signed(th_hi);
    assign lt_lo   = $signed(v_in) < $signed(th_lo);
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        spike_det = 1'b0;
        if (v_valid) begin
            case (state_q)
                ARMED: begin
                    if (gt_hi) begin
                        spike_det = 1'b1;
                        state_d   = REFRACT;
                    end
                end
                REFRACT: begin
                    if (lt_lo) begin
                        state_d = ARMED;
                    end
                end
                default: state_d = ARMED;
            endcase
            cnt_d = spike_det ? '0 : cnt_inc;
            if (spike_det) begin
                first_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARMED;
            cnt_q      <= '0;
            first_q    <= 1'b1;
            spike_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            spike_q <= spike_det;
            // A drop in the same cycle as a clear keeps the flag set.
            if (spike_det && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign pop = isi_valid & isi_ready;

    izh_isi_fifo #(
        .W     (ISI_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (spike_det),
        .push_data_i ({first_q, cnt_inc}),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (isi_valid),
        .full_o      (fifo_full),
        .level_o     (fifo_level)
    );

    assign isi_first = head[ISI_W];
    assign isi_data  = head[ISI_W-1:0];
    assign spike     = spike_q;
    assign overflow  = overflow_q;

`ifdef IZH_SPIKE_RATE_EN
    logic [WIN_LG2-1:0] win_q;
    logic [7:0]         spk_q;
    logic [7:0]         spk_inc;
    logic [7:0]         rate_q;
    logic               rate_valid_q;

    assign spk_inc = (spike_det && spk_q != 8'hFF) ? spk_q + 8'd1 : spk_q;

    // The last sample of the window is folded into the published count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q        <= '0;
            spk_q        <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
        end else begin
            rate_valid_q <= 1'b0;
            if (v_valid) begin
                win_q <= win_q + 1'b1;
                if (&win_q) begin
                    rate_q       <= spk_inc;
                    rate_valid_q <= 1'b1;
                    spk_q        <= '0;
                end else begin
                    spk_q <= spk_inc;
                end
            end
        end
    end

    assign rate       = rate_q;
    assign rate_valid = rate_valid_q;
`else
    assign rate       = '0;
    assign rate_valid = 1'b0;
`endif

endmodule

// File: tb/tb_izh_spike_isi_encoder.sv
// Directed bench for izh_spike_isi_encoder: scoreboard of expected ISI entries
// popped by a monitor, plus direct checks of spike, level, overflow and rate.
module tb_izh_spike_isi_encoder;

    localparam int ISI_W   = 16;
    localparam int DEPTH   = 4;
    localparam int WIN_LG2 = 4;
    localparam int LVL_W   = 3;
    localparam int SAT_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             v_valid;
    logic [7:0]       v_in;
    logic [7:0]       th_hi;
    logic [7:0]       th_lo;
    logic             spike;
    logic             isi_valid;
    logic             isi_ready;
    logic [ISI_W-1:0] isi_data;
    logic             isi_first;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;
    logic             ovf_clr;
    logic [7:0]       rate;
    logic             rate_valid;

    logic             s_v_valid;
    logic [7:0]       s_v_in;
    logic             s_spike;
    logic             s_isi_valid;
    logic [SAT_W-1:0] s_isi_data;
    logic             s_isi_first;
    logic [LVL_W-1:0] s_fifo_level;
    logic             s_overflow;
    logic [7:0]       s_rate;
    logic             s_rate_valid;

    logic [ISI_W:0] exp_q[$];
    logic [ISI_W:0] exp_e;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    izh_spike_isi_encoder #(.ISI_W(ISI_W), .DEPTH(DEPTH), .WIN_LG2(WIN_LG2)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .v_valid    (v_valid),
        .v_in       (v_in),
        .th_hi      (th_hi),
        .th_lo      (th_lo),
        .spike      (spike),
        .isi_valid  (isi_valid),
        .isi_ready  (isi_ready),
        .isi_data   (isi_data),
        .isi_first  (isi_first),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .rate       (rate),
        .rate_valid (rate_valid)
    );

    izh_spike_isi_encoder #(.ISI_W(SAT_W), .DEPTH(DEPTH), .WIN_LG2(WIN_LG2)) u_dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .v_valid    (s_v_valid),
        .v_in       (s_v_in),
        .th_hi      (th_hi),
        .th_lo      (th_lo),
        .spike      (s_spike),
        .isi_valid  (s_isi_valid),
        .isi_ready  (1'b0),
        .isi_data   (s_isi_data),
        .isi_first  (s_isi_first),
        .fifo_level (s_fifo_level),
        .overflow   (s_overflow),
        .ovf_clr    (1'b0),
        .rate       (s_rate),
        .rate_valid (s_rate_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] v);
        v_valid = 1'b1;
        v_in    = v;
        @(posedge clk);
        #1;
        v_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        isi_ready = 1'b1;
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every accepted head entry must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && isi_valid && isi_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL isi_pop: unexpected entry first=%0d isi=%0d", isi_first, isi_data);
            end else begin
                exp_e = exp_q.pop_front();
                if ({isi_first, isi_data} !== exp_e) begin
                    n_fail++;
                    $display("FAIL isi_pop: got first=%0d isi=%0d expected first=%0d isi=%0d",
                             isi_first, isi_data, exp_e[ISI_W], exp_e[ISI_W-1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        v_valid   = 1'b1;
        v_in      = 8'h13;
        th_hi     = 8'h13;
        th_lo     = 8'hF0;
        isi_ready = 1'b0;
        ovf_clr   = 1'b0;
        s_v_valid = 1'b0;
        s_v_in    = 8'h00;
        idle(2);

        // Reset state
        chk("rst_spike", 32'(spike), 32'd0);
        chk("rst_isi_valid", 32'(isi_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_isi_data", 32'(isi_data), 32'd0);
        chk("rst_isi_first", 32'(isi_first), 32'd0);
        chk("rst_rate", 32'(rate), 32'd0);
        chk("rst_rate_valid", 32'(rate_valid), 32'd0);
        rst_n = 1'b1;

        // Threshold equality does not spike; first spike measured from reset
        for (int i = 0; i < 3; i++) begin
            drive(8'h13);
            chk("eq_th_no_spike", 32'(spike), 32'd0);
        end
        exp_q.push_back({1'b1, 16'd4});
        drive(8'h14);
        chk("t1_spike", 32'(spike), 32'd1);
        chk("t1_isi_valid", 32'(isi_valid), 32'd1);
        chk("t1_level", 32'(fifo_level), 32'd1);
        chk("t1_head_isi", 32'(isi_data), 32'd4);
        chk("t1_head_first", 32'(isi_first), 32'd1);
        idle(1);
        chk("t1_spike_pulse_end", 32'(spike), 32'd0);
        chk("t1_head_stable", 32'(isi_data), 32'd4);
        drain();

        // Hysteresis: 0x10 and 0x00 do not re-arm, 0xEF does
        drive(8'hEF);
        exp_q.push_back({1'b0, 16'd2});
        drive(8'h20);
        chk("t2_spike_a", 32'(spike), 32'd1);
        drive(8'h10);
        drive(8'h00);
        drive(8'hEF);
        chk("t2_no_spike", 32'(spike), 32'd0);
        exp_q.push_back({1'b0, 16'd4});
        drive(8'h20);
        chk("t2_spike_b", 32'(spike), 32'd1);
        drain();

        // Fill the FIFO and drop the fifth ISI; 0x80 is negative so must not spike
        isi_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(8'hE0);
            for (int j = 0; j < k; j++) drive(8'h80);
            if (k < 4) exp_q.push_back({1'b0, 16'(2 + k)});
            drive(8'h20);
        end
        chk("t3_level_full", 32'(fifo_level), 32'd4);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_head_isi", 32'(isi_data), 32'd2);
        chk("t3_head_first", 32'(isi_first), 32'd0);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", 32'(overflow), 32'd0);

        // Push into full FIFO while popping: accepted, no overflow
        drive(8'hE0);
        isi_ready = 1'b1;
        exp_q.push_back({1'b0, 16'd2});
        drive(8'h20);
        isi_ready = 1'b0;
        chk("t4_level", 32'(fifo_level), 32'd4);
        chk("t4_overflow", 32'(overflow), 32'd0);
        drain();
        chk("t4_level_empty", 32'(fifo_level), 32'd0);
        chk("t4_isi_valid", 32'(isi_valid), 32'd0);

        // ISI saturation on the narrow instance
        s_v_valid = 1'b1;
        s_v_in    = 8'h00;
        idle(20);
        s_v_in = 8'h20;
        idle(1);
        s_v_valid = 1'b0;
        chk("t5_spike", 32'(s_spike), 32'd1);
        chk("t5_isi_valid", 32'(s_isi_valid), 32'd1);
        chk("t5_isi_sat", 32'(s_isi_data), 32'd15);
        chk("t5_isi_first", 32'(s_isi_first), 32'd1);

        // Rate window after a fresh reset: 3 spikes in 16 samples
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        isi_ready = 1'b1;
        exp_q.push_back({1'b1, 16'd1});
        exp_q.push_back({1'b0, 16'd2});
        exp_q.push_back({1'b0, 16'd2});
        for (int i = 0; i < 3; i++) begin
            drive(8'h20);
            drive(8'hE0);
        end
        for (int i = 0; i < 9; i++) drive(8'h00);
        chk("t6_rate_valid_early", 32'(rate_valid), 32'd0);
        drive(8'h00);
`ifdef IZH_SPIKE_RATE_EN
        chk("t6_rate", 32'(rate), 32'd3);
        chk("t6_rate_valid", 32'(rate_valid), 32'd1);
        idle(1);
        chk("t6_rate_valid_pulse", 32'(rate_valid), 32'd0);
        chk("t6_rate_hold", 32'(rate), 32'd3);
`else
        chk("t6_rate_off", 32'(rate), 32'd0);
        chk("t6_rate_valid_off", 32'(rate_valid), 32'd0);
`endif
        drain();

        // Asynchronous reset mid-operation clears outputs immediately
        isi_ready = 1'b0;
        drive(8'h20);
        chk("t7_spike", 32'(spike), 32'd1);
        chk("t7_level", 32'(fifo_level), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_spike", 32'(spike), 32'd0);
        chk("t7_rst_level", 32'(fifo_level), 32'd0);
        chk("t7_rst_isi_valid", 32'(isi_valid), 32'd0);
        chk("t7_rst_rate", 32'(rate), 32'd0);
        idle(1);
        rst_n = 1'b1;
        idle(2);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
